// File: rtl/seven_segment8_pkg.sv
// Shared definitions for the seven_segment8 display driver and its decoder:
// glyph table, digit count and decoder FSM states.
package seven_segment8_pkg;

  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } dec_state_e;

  // Active-low g..a pattern for each hex digit
  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Position of the low bit in an active-low one-hot anode word
  function automatic logic [2:0] anode_index(input logic [DIGITS-1:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      idx = an[i] ? idx : 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_segment8_decoder_if.sv
// Display drive lines plus reconstructed frame outputs of the seven-segment decoder.
interface seven_segment8_decoder_if;
  logic [7:0]  segment;
  logic [7:0]  anode;
  logic [31:0] data_out;
  logic [7:0]  dp_out;
  logic        blank_out;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    output segment, anode,
    input  data_out, dp_out, blank_out, frame_valid, frame_err
  );

  modport slave (
    input  segment, anode,
    output data_out, dp_out, blank_out, frame_valid, frame_err
  );
endinterface

// File: rtl/seven_segment8_decoder_glyph_decode.sv
// Combinational reverse lookup of a seven-segment pattern into its hex nibble.
module seg_glyph_decode
  import seven_segment8_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table match; unknown patterns report invalid with a zero nibble
  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      glyph_of(4'h0): nibble = 4'h0;
      glyph_of(4'h1): nibble = 4'h1;
      glyph_of(4'h2): nibble = 4'h2;
      glyph_of(4'h3): nibble = 4'h3;
      glyph_of(4'h4): nibble = 4'h4;
      glyph_of(4'h5): nibble = 4'h5;
      glyph_of(4'h6): nibble = 4'h6;
      glyph_of(4'h7): nibble = 4'h7;
      glyph_of(4'h8): nibble = 4'h8;
      glyph_of(4'h9): nibble = 4'h9;
      glyph_of(4'hA): nibble = 4'hA;
      glyph_of(4'hB): nibble = 4'hB;
      glyph_of(4'hC): nibble = 4'hC;
      glyph_of(4'hD): nibble = 4'hD;
      glyph_of(4'hE): nibble = 4'hE;
      glyph_of(4'hF): nibble = 4'hF;
      default: begin
        valid  = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment8_decoder.sv
// Receiver for a multiplexed 8-digit seven-segment bus: captures each digit once
// its lines are stable and commits a full 32-bit frame, or reports a blank display.
module seven_segment8_decoder
  import seven_segment8_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int REFRESH_RATE  = 200,
  parameter int SETTLE_CYCLES = 16,
  parameter int BLANK_TIMEOUT = 2 * CLK_FREQUENCY / (REFRESH_RATE * 8)
) (
  input logic                     clk,
  input logic                     rst,
  seven_segment8_decoder_if.slave bus
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int BCW = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [SCW-1:0] SETTLE_MAX  = SCW'(SETTLE_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [BCW-1:0] BLANK_MAX   = BCW'(BLANK_TIMEOUT);
  localparam logic [BCW-1:0] BLANK_LAST  = BCW'(BLANK_TIMEOUT - 1);
  localparam logic [7:0]     AN_OFF      = 8'hFF;

  logic [7:0]        seg_meta_r, s_seg_r, an_meta_r, s_an_r;
  logic [15:0]       prev_r;
  logic              change_s;
  logic [SCW-1:0]    stable_cnt_r;
  logic [BCW-1:0]    blank_cnt_r;
  logic              blank_fire_s;
  dec_state_e        state_r, state_s;
  logic              capture_s;
  logic              commit_s;
  logic              one_hot_s;
  logic [2:0]        idx_s;
  logic              glyph_valid_s;
  logic [3:0]        glyph_nib_s;
  logic [31:0]       shadow_nib_r;
  logic [DIGITS-1:0] shadow_dp_r;
  logic [DIGITS-1:0] seen_r;
  logic              err_acc_r;
  logic [31:0]       data_r;
  logic [7:0]        dp_r;
  logic              blank_r, valid_r, err_r;

  assign change_s     = ({s_an_r, s_seg_r} != prev_r);
  assign blank_fire_s = (s_an_r == AN_OFF) && (blank_cnt_r == BLANK_LAST);
  assign commit_s     = (seen_r == 8'hFF);
  assign one_hot_s    = $onehot(~s_an_r);
  assign idx_s        = anode_index(s_an_r);

  seg_glyph_decode u_glyph (
    .pattern (s_seg_r[6:0]),
    .valid   (glyph_valid_s),
    .nibble  (glyph_nib_s)
  );

  // Two-flop synchronizers; idle lines read as all-off after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta_r <= 8'hFF;
      s_seg_r    <= 8'hFF;
      an_meta_r  <= 8'hFF;
      s_an_r     <= 8'hFF;
      prev_r     <= 16'hFFFF;
    end else begin
      seg_meta_r <= bus.segment;
      s_seg_r    <= seg_meta_r;
      an_meta_r  <= bus.anode;
      s_an_r     <= an_meta_r;
      prev_r     <= {s_an_r, s_seg_r};
    end
  end

  // Settle and blank-interval counters, both saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt_r <= '0;
      blank_cnt_r  <= '0;
    end else begin
      if (change_s) begin
        stable_cnt_r <= '0;
      end else if (stable_cnt_r != SETTLE_MAX) begin
        stable_cnt_r <= stable_cnt_r + SCW'(1);
      end else begin
        stable_cnt_r <= stable_cnt_r;
      end
      if (s_an_r != AN_OFF) begin
        blank_cnt_r <= '0;
      end else if (blank_cnt_r != BLANK_MAX) begin
        blank_cnt_r <= blank_cnt_r + BCW'(1);
      end else begin
        blank_cnt_r <= blank_cnt_r;
      end
    end
  end

  // Digit tracking state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; capture fires once per settled digit
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_an_r != AN_OFF) begin
          state_s = ST_SETTLING;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLING: begin
        if (change_s) begin
          state_s = (s_an_r == AN_OFF) ? ST_IDLE : ST_SETTLING;
        end else if (stable_cnt_r == SETTLE_LAST) begin
          capture_s = 1'b1;
          state_s   = ST_HELD;
        end else begin
          state_s = ST_SETTLING;
        end
      end
      ST_HELD: begin
        if (change_s) begin
          state_s = (s_an_r == AN_OFF) ? ST_IDLE : ST_SETTLING;
        end else begin
          state_s = ST_HELD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shadow frame: a recaptured digit simply overwrites its slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_nib_r <= 32'h0;
      shadow_dp_r  <= 8'h00;
    end else if (capture_s && one_hot_s) begin
      shadow_nib_r[4*idx_s +: 4] <= glyph_valid_s ? glyph_nib_s : 4'h0;
      shadow_dp_r[idx_s]         <= ~s_seg_r[7];
    end else begin
      shadow_nib_r <= shadow_nib_r;
      shadow_dp_r  <= shadow_dp_r;
    end
  end

  // Which digits have been seen this frame, and whether anything looked wrong
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_r    <= 8'h00;
      err_acc_r <= 1'b0;
    end else if (commit_s || blank_fire_s) begin
      seen_r    <= 8'h00;
      err_acc_r <= 1'b0;
    end else if (capture_s && one_hot_s) begin
      seen_r[idx_s] <= 1'b1;
      err_acc_r     <= err_acc_r | ~glyph_valid_s;
    end else if (capture_s) begin
      err_acc_r <= 1'b1;
    end else begin
      seen_r    <= seen_r;
      err_acc_r <= err_acc_r;
    end
  end

  // Committed outputs; a blank commit keeps the last data and decimal points
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= 32'h0;
      dp_r    <= 8'h00;
      blank_r <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (commit_s) begin
      data_r  <= shadow_nib_r;
      dp_r    <= shadow_dp_r;
      blank_r <= 1'b0;
      err_r   <= err_acc_r;
      valid_r <= 1'b1;
    end else if (blank_fire_s) begin
      blank_r <= 1'b1;
      err_r   <= 1'b0;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.data_out    = data_r;
  assign bus.dp_out      = dp_r;
  assign bus.blank_out   = blank_r;
  assign bus.frame_valid = valid_r;
  assign bus.frame_err   = err_r;

endmodule

// File: doc/seven_segment8_decoder.md
# seven_segment8_decoder

Receives the multiplexed 8-digit seven-segment drive lines (`segment`/`anode`) and reconstructs the displayed 32-bit hex value, decimal points and blank state. It is the receiving end of the `seven_segment8` display driver: it snoops a driver's outputs for loopback self-test, or reads a display bus from another board. Each digit is captured only after its drive lines have settled. A new frame is committed once all eight digits have been captured.

## Interface
- `CLK_FREQUENCY`, 100_000_000, clock frequency in Hz
- `REFRESH_RATE`, 200, expected full-display refresh rate in Hz
- `SETTLE_CYCLES`, 16, consecutive unchanged synchronized cycles required before a digit is captured (≥2)
- `BLANK_TIMEOUT`, 2*CLK_FREQUENCY/(REFRESH_RATE*8), cycles with all anodes off before blank is declared
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `segment`  in  8  active-low; [6:0] = g,f,e,d,c,b,a; [7] = decimal point
- `anode`  in  8  active-low digit enables; bit i selects digit i, which shows `data_out[4i+3:4i]`
- `data_out`  out  32  last committed hex value
- `dp_out`  out  8  last committed decimal points, active-high
- `blank_out`  out  1  display observed blank
- `frame_valid`  out  1  one-cycle pulse on every commit (frame or blank)
- `frame_err`  out  1  error status of the last commit; held until the next commit

## Operation
- Both `segment` and `anode` pass through a 2-flop synchronizer. All further logic uses the synchronized values `s_seg` and `s_an`.
- Change detect: `stable_cnt` resets to 0 whenever `{s_an,s_seg}` differs from the previous cycle. Otherwise it increments and saturates at `SETTLE_CYCLES`.
- FSM states:
  - IDLE: `s_an == 8'hFF`.
  - SETTLING: an anode is active and the counter is below `SETTLE_CYCLES`.
  - HELD: the current digit has been processed; wait for the next change.
  - Any input change returns the FSM to SETTLING, or to IDLE if all anodes are off.
- Capture happens on the cycle `stable_cnt` reaches `SETTLE_CYCLES - 1` while in SETTLING. The FSM then moves to HELD.
  - If `s_an` has exactly one zero at index i: `shadow_nib[i]` <= glyph decode of `s_seg[6:0]`, `shadow_dp[i]` <= `~s_seg[7]`, and `seen[i]` <= 1.
  - If the glyph is not in the table: nibble <= 0, `err_acc` <= 1, and `seen[i]` is still set.
  - If more than one anode is low: `err_acc` <= 1, nothing is captured, and `seen` is unchanged.
  - Recapturing an already-seen digit overwrites its shadow value.
- Frame commit, on the cycle after `seen` becomes 8'hFF:
  - `data_out` <= shadow, `dp_out` <= `shadow_dp`, `blank_out` <= 0.
  - `frame_err` <= `err_acc`, `frame_valid` = 1.
  - `seen` and `err_acc` are cleared.
- Blank detect:
  - `blank_cnt` counts consecutive cycles with `s_an == 8'hFF` and clears on any active anode.
  - On reaching `BLANK_TIMEOUT`: `blank_out` <= 1, `frame_valid` pulses, `frame_err` <= 0, and `seen`/`err_acc` are cleared.
  - `data_out` and `dp_out` are held. Blank fires only once per blank interval.
- Glyph table (active-low g..a, hex digits 0–F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

## Timing
- Reset values: `data_out` = 0, `dp_out` = 0, `blank_out` = 0, `frame_valid` = 0, `frame_err` = 0. FSM in IDLE; all counters, `seen` and `err_acc` cleared.
- Capture latency: 2 (synchronizer) + `SETTLE_CYCLES` cycles after the input pins change.
- Commit latency: 1 cycle after the 8th distinct capture.
- Blank latency: 2 + `BLANK_TIMEOUT` cycles after the anodes go inactive.
- A digit held for fewer than `SETTLE_CYCLES` cycles is ignored.
- Reset asserted mid-frame discards the partial shadow. No `frame_valid` is produced.
- Capture and commit never coincide: commit is registered, and a new capture needs at least `SETTLE_CYCLES` cycles.

## Structure
- Package `seven_segment8_pkg`:
  - glyph constant table (shared with the driver)
  - FSM state typedef
  - `DIGITS` = 8 constant
- Sub-module `seg_glyph_decode`: combinational 7-bit pattern to {valid, nibble}. Instantiate it once.

## Test plan
- Loopback with `seven_segment8` (`REFRESH_RATE` raised for simulation), `data_in` = 32'hDEADBEEF, `dp_in` = 8'hA5 -> `frame_valid` pulses; `data_out` = DEADBEEF, `dp_out` = A5, `frame_err` = 0.
- Change `data_in` to 32'h01234567 mid-frame -> the first commit may mix old and new digits; the next commit = 01234567.
- Driver blank = 1 for 3×`BLANK_TIMEOUT` -> exactly one `frame_valid` with `blank_out` = 1; `data_out` keeps its previous value.
- Inject glyph 7'h7F on digit 3, others valid -> commit with `frame_err` = 1 and nibble 3 = 0.
- Glitch: 5-cycle foreign pattern between digits (`SETTLE_CYCLES` = 16) -> ignored; data correct; `frame_err` = 0. Two anodes low for 20 cycles -> `frame_err` = 1.
- Assert `rst` after 5 digits captured -> all outputs 0; the next full frame commits correctly.
